// File: rtl/ttc_pkg.sv
// Shared types for the truth-table response checker: FSM state encoding and
// vector-space sizing helpers.
package ttc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VEC,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } ttc_state_e;

    localparam int N_IN_DEFAULT = 3;
    localparam int N_VEC        = 2 ** N_IN_DEFAULT;

    // Number of distinct stimulus vectors for an n_in-input DUT.
    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/ttc_err_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones and
// flags saturation.
module ttc_err_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat_flag
);

    assign sat_flag = &count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !sat_flag) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Response checker: samples a combinational DUT output a fixed settle time
// after each stimulus vector, compares it to EXP_TABLE and tracks coverage.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int                  N_IN      = 3,
    parameter logic [2**N_IN-1:0]  EXP_TABLE = 8'hE8,
    parameter int                  SETTLE    = 2,
    parameter int                  ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [N_IN-1:0]  vec_in,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int NUM_VEC = n_vec(N_IN);

    ttc_state_e         state_q, state_d;
    logic [3:0]         cnt_q;
    logic [N_IN-1:0]    vec_q;
    logic [NUM_VEC-1:0] mask_q;
    logic [NUM_VEC-1:0] mask_upd;
    logic               mismatch;
    logic               err_inc;
    logic               err_sat;

    assign mismatch = (z_in != EXP_TABLE[vec_q]);
    assign mask_upd = mask_q | (NUM_VEC'(1) << vec_q);
    assign err_inc  = (state_q == ST_CHECK) && mismatch && !start && !err_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_WAIT_VEC: begin
                busy = 1'b1;
                if (vec_valid) begin
                    state_d = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                // A fresh vector restarts the settle window on the new value.
                if (!vec_valid && cnt_q == 4'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy    = 1'b1;
                state_d = (&mask_upd) ? ST_DONE : ST_WAIT_VEC;
            end
            default: ;
        endcase
        if (start) begin
            state_d = ST_WAIT_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            vec_q           <= '0;
            mask_q          <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (start) begin
            mask_q          <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state_q)
                ST_WAIT_VEC, ST_SETTLE: begin
                    if (vec_valid) begin
                        vec_q <= vec_in;
                        cnt_q <= 4'(SETTLE);
                    end else if (state_q == ST_SETTLE) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    mask_q <= mask_upd;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= vec_q;
                    end
                end
                default: ;
            endcase
        end
    end

    ttc_err_counter #(
        .W(ERR_W)
    ) u_err_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .inc      (err_inc),
        .count    (err_count),
        .sat_flag (err_sat)
    );

    assign done = (state_q == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default instance (majority, 8-bit
// errors) plus a 2-bit error counter instance for saturation.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vec_valid;
    logic [2:0] vec_in;
    logic       z_in;

    logic       busy_a, done_a, pass_a, fev_a;
    logic [7:0] err_a;
    logic [2:0] fvec_a;

    logic       busy_b, done_b, pass_b, fev_b;
    logic [1:0] err_b;
    logic [2:0] fvec_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    truth_table_checker dut_a (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_in(vec_in), .z_in(z_in), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a),
        .first_err_vec(fvec_a)
    );

    truth_table_checker #(.ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_in(vec_in), .z_in(z_in), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_valid(fev_b),
        .first_err_vec(fvec_b)
    );

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] v, input logic z);
        vec_in    = v;
        z_in      = z;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    // Vector pulse, then wait through the compare edge plus a small gap.
    task automatic send(input logic [2:0] v, input logic z);
        pulse(v, z);
        repeat (3) tick();
        repeat (2) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = 3'd0; z_in = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_fev", 32'(fev_a), 32'd0);
        rst = 1'b0;
        tick();
        pulse(3'd3, 1'b0);
        tick();
        check("idle_ignores_vec", 32'(busy_a), 32'd0);

        // Scenario 1: all correct, in order
        do_start();
        check("s1_busy", 32'(busy_a), 32'd1);
        for (int v = 0; v < 7; v++) send(3'(v), maj(3'(v)));
        check("s1_not_done_yet", 32'(done_a), 32'd0);
        pulse(3'd7, 1'b1);
        tick(); tick();
        check("s1_done_latency_early", 32'(done_a), 32'd0);
        tick();
        check("s1_done", 32'(done_a), 32'd1);
        check("s1_pass", 32'(pass_a), 32'd1);
        check("s1_err", 32'(err_a), 32'd0);
        check("s1_fev", 32'(fev_a), 32'd0);
        check("s1_busy_low", 32'(busy_a), 32'd0);
        pulse(3'd0, 1'b1);
        repeat (4) tick();
        check("s1_done_ignores_vec", 32'(err_a), 32'd0);

        // Scenario 2: vectors 5 and 6 wrong
        do_start();
        check("s2_done_cleared", 32'(done_a), 32'd0);
        for (int v = 0; v < 8; v++) begin
            send(3'(v), maj(3'(v)) ^ ((v == 5) || (v == 6)));
            if (v == 5) begin
                check("s2_err_after5", 32'(err_a), 32'd1);
                check("s2_fvec_after5", 32'(fvec_a), 32'd5);
            end
        end
        check("s2_err", 32'(err_a), 32'd2);
        check("s2_fvec", 32'(fvec_a), 32'd5);
        check("s2_fev", 32'(fev_a), 32'd1);
        check("s2_pass", 32'(pass_a), 32'd0);
        check("s2_done", 32'(done_a), 32'd1);

        // Scenario 3: out of order, duplicate 3 wrong twice
        do_start();
        send(3'd7, 1'b1);
        send(3'd3, 1'b0);
        send(3'd3, 1'b0);
        send(3'd0, 1'b0);
        send(3'd1, 1'b0);
        send(3'd2, 1'b0);
        send(3'd4, 1'b0);
        send(3'd5, 1'b1);
        check("s3_not_done_before6", 32'(done_a), 32'd0);
        check("s3_err_before6", 32'(err_a), 32'd2);
        send(3'd6, 1'b1);
        check("s3_done", 32'(done_a), 32'd1);
        check("s3_err", 32'(err_a), 32'd2);
        check("s3_fvec", 32'(fvec_a), 32'd3);

        // Scenario 4: retrigger, only the second vector is checked
        do_start();
        pulse(3'd1, 1'b1);
        pulse(3'd2, 1'b1);
        tick(); tick();
        check("s4_no_early_check", 32'(err_a), 32'd0);
        check("s4_busy", 32'(busy_a), 32'd1);
        tick();
        check("s4_err", 32'(err_a), 32'd1);
        check("s4_fvec", 32'(fvec_a), 32'd2);
        repeat (2) tick();
        send(3'd0, 1'b0);
        send(3'd3, 1'b1);
        send(3'd4, 1'b0);
        send(3'd5, 1'b1);
        send(3'd6, 1'b1);
        send(3'd7, 1'b1);
        check("s4_vec1_uncovered", 32'(done_a), 32'd0);
        send(3'd1, 1'b0);
        check("s4_done", 32'(done_a), 32'd1);
        check("s4_err_final", 32'(err_a), 32'd1);

        // Scenario 5: reset mid-run
        do_start();
        send(3'd0, 1'b1);
        send(3'd1, 1'b0);
        send(3'd2, 1'b0);
        send(3'd3, 1'b1);
        check("s5_err_prereset", 32'(err_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_busy", 32'(busy_a), 32'd0);
        check("s5_done", 32'(done_a), 32'd0);
        check("s5_err", 32'(err_a), 32'd0);
        check("s5_fev", 32'(fev_a), 32'd0);
        check("s5_fvec", 32'(fvec_a), 32'd0);
        pulse(3'd4, 1'b0);
        repeat (5) tick();
        check("s5_vec_ignored_err", 32'(err_a), 32'd0);
        check("s5_vec_ignored_busy", 32'(busy_a), 32'd0);
        do_start();
        check("s5_restart_busy", 32'(busy_a), 32'd1);

        // Scenario 6: all wrong, 2-bit counter saturates
        do_start();
        for (int v = 0; v < 8; v++) send(3'(v), ~maj(3'(v)));
        check("s6_err_sat", 32'(err_b), 32'd3);
        check("s6_done_b", 32'(done_b), 32'd1);
        check("s6_pass_b", 32'(pass_b), 32'd0);
        check("s6_err_wide", 32'(err_a), 32'd8);
        check("s6_fvec_b", 32'(fvec_b), 32'd0);
        do_start();
        check("s6_restart_done", 32'(done_b), 32'd0);
        check("s6_restart_err", 32'(err_b), 32'd0);
        check("s6_restart_busy", 32'(busy_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
